clk_gate_ctrl: RTL

Multi-domain automatic clock-gating controller. It watches per-domain activity, gates each idle domain's clock after a programmable idle interval, and re-enables it through a wake-up handshake. Each `cg_en[i]` drives the `en` pin of one latch-based ICG cell; DFT bypass (`test_en`) goes straight to the ICG and is not handled here. The block sits in the always-on clock domain, next to the ICG cells it controls.

---
 rtl/clk_gate_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/clk_gate_ctrl.sv
// Multi-domain automatic clock-gating controller: per-domain idle detection,
// threshold-based gating of the ICG enable, and a fixed-latency wake handshake.
module clk_gate_ctrl #(
    parameter int N_DOM    = 4,
    parameter int CNT_W    = 8,
    parameter int WAKE_LAT = 2,
    parameter int EVT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_DOM-1:0] busy,
    input  logic [N_DOM-1:0] wake_req,
    output logic [N_DOM-1:0] wake_ack,
    input  logic [N_DOM-1:0] gate_allow,
    input  logic             force_on,
    input  logic [CNT_W-1:0] idle_thresh,
    output logic [N_DOM-1:0] cg_en,
    output logic [N_DOM-1:0] gated,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam int WL_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
    localparam logic [WL_W-1:0] WCNT_LAST = WL_W'(WAKE_LAT - 1);
    localparam int SUM_W = EVT_W + 5;

    typedef enum logic [1:0] {
        RUN,
        IDLE_CNT,
        OFF,
        WAKE
    } state_t;

    logic [N_DOM-1:0] gate_evt;

    for (genvar g = 0; g < N_DOM; g++) begin : g_dom
        state_t          state;
        logic [CNT_W-1:0] cnt;
        logic [WL_W-1:0]  wcnt;
        logic             en_q;
        logic             gated_q;
        logic             idle;

        assign idle        = gate_allow[g] & ~busy[g] & ~wake_req[g] & ~force_on;
        assign gate_evt[g] = (state == IDLE_CNT) && idle && (cnt >= idle_thresh);
        assign wake_ack[g] = wake_req[g] && (state == RUN);
        assign cg_en[g]    = en_q;
        assign gated[g]    = gated_q;

        // Enable/gated are flopped alongside the state so the ICG sees a clean register output.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= RUN;
                cnt     <= '0;
                wcnt    <= '0;
                en_q    <= 1'b1;
                gated_q <= 1'b0;
            end else begin
                unique case (state)
                    RUN: begin
                        if (idle) begin
                            state <= IDLE_CNT;
                            cnt   <= '0;
                        end
                    end
                    IDLE_CNT: begin
                        if (!idle) begin
                            state <= RUN;
                        end else if (cnt >= idle_thresh) begin
                            state   <= OFF;
                            en_q    <= 1'b0;
                            gated_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    OFF: begin
                        if (!idle) begin
                            state   <= WAKE;
                            wcnt    <= '0;
                            en_q    <= 1'b1;
                            gated_q <= 1'b0;
                        end
                    end
                    WAKE: begin
                        if (wcnt == WCNT_LAST) begin
                            state <= RUN;
                        end else begin
                            wcnt <= wcnt + WL_W'(1);
                        end
                    end
                    default: begin
                        state   <= RUN;
                        en_q    <= 1'b1;
                        gated_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic [SUM_W-1:0] evt_sum;
    logic [EVT_W-1:0] evt_next;

    always_comb begin
        evt_sum = SUM_W'(evt_cnt);
        for (int unsigned i = 0; i < N_DOM; i++) begin
            evt_sum = evt_sum + SUM_W'(gate_evt[i]);
        end
        if (evt_sum > SUM_W'({EVT_W{1'b1}})) begin
            evt_next = '1;
        end else begin
            evt_next = evt_sum[EVT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt <= '0;
        end else begin
            evt_cnt <= evt_next;
        end
    end

endmodule
